game_status_tracker: RTL



---
 rtl/game_status_pkg.sv | 21 ++
 rtl/tick_divider.sv | 36 +++
 rtl/game_status_tracker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/game_status_pkg.sv
// Shared types and widths for the game status tracker and its helpers.
package game_status_pkg;

  localparam int BAR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_t;

  typedef enum logic {
    MODE_CLASSIC,
    MODE_INFINITY
  } mode_t;

  function automatic logic [5:0] sat_min6(input logic [5:0] value, input logic [5:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Cycle counter used two ways: free-running wrap divider (LOAD_MODE=0, tc pulses on wrap)
// or loadable countdown (LOAD_MODE=1, tc high while the count sits at zero).
module tick_divider #(
  parameter int CYCLES    = 4,
  parameter bit LOAD_MODE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic load,
  output logic tc
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (LOAD_MODE && load) begin
      count <= LAST;
    end else if (run) begin
      if (LOAD_MODE) begin
        if (count != '0) count <= count - W'(1);
      end else begin
        count <= (count == LAST) ? '0 : count + W'(1);
      end
    end
  end

  assign tc = LOAD_MODE ? (count == '0) : (run && (count == LAST));

endmodule

// File: rtl/game_status_tracker.sv
// HP / time-budget owner for classic and infinity modes; flags game over to the mode controller.
// Build option: define PAUSE_EN to let the pause input freeze counters and ignore hit/pickup in RUN.
//
// state | meaning
// IDLE  | no game; outputs and counters held at 0
// RUN   | game in progress in the mode latched on entry
// OVER  | HP or time exhausted; game_over high, values frozen
module game_status_tracker
  import game_status_pkg::*;
#(
  parameter int TICK_CYCLES   = 25_000_000,
  parameter int HP_INIT       = 9,
  parameter int HP_MAX        = 9,
  parameter int TIME_INIT     = 18,
  parameter int TIME_MAX      = 18,
  parameter int TIME_BONUS    = 3,
  parameter int INVULN_CYCLES = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_game_classic,
  input  logic             enable_game_infinity,
  input  logic             hit,
  input  logic             pickup,
  input  logic             pause,
  output logic [BAR_W-1:0] HP_print,
  output logic [BAR_W-1:0] time_print,
  output logic             game_over,
  output logic             over_pulse
);

  state_t state;
  mode_t  mode;

  logic       any_en;
  logic       paused;
  logic       run_go;
  logic       tick;
  logic       inv_done;
  logic       hit_ok;
  logic       inv_load;
  logic       cnt_clear;
  logic [5:0] time_dec;
  logic [5:0] time_next;
  logic [BAR_W-1:0] hp_up;

`ifdef PAUSE_EN
  assign paused = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused       = 1'b0;
`endif

  assign any_en    = enable_game_classic | enable_game_infinity;
  assign run_go    = (state == RUN) && !paused;
  assign cnt_clear = (state == IDLE) || !any_en;
  assign hit_ok    = hit && inv_done;
  // An accepted hit cancelled by a same-cycle pickup must not open a window.
  assign inv_load  = run_go && any_en && (mode == MODE_CLASSIC) && hit_ok && !pickup;

  tick_divider #(
    .CYCLES   (TICK_CYCLES),
    .LOAD_MODE(1'b0)
  ) u_time_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .run  (run_go && (mode == MODE_INFINITY)),
    .load (1'b0),
    .tc   (tick)
  );

  tick_divider #(
    .CYCLES   (INVULN_CYCLES),
    .LOAD_MODE(1'b1)
  ) u_invuln (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .run  (run_go && (mode == MODE_CLASSIC)),
    .load (inv_load),
    .tc   (inv_done)
  );

  always_comb begin
    time_dec = {1'b0, time_print};
    if (tick && (time_print != '0)) time_dec = {1'b0, time_print} - 6'd1;
    time_next = time_dec;
    if (pickup) time_next = sat_min6(time_dec + 6'(TIME_BONUS), 6'(TIME_MAX));
    hp_up = (HP_print >= BAR_W'(HP_MAX)) ? BAR_W'(HP_MAX) : HP_print + BAR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= MODE_CLASSIC;
      HP_print   <= '0;
      time_print <= '0;
      game_over  <= 1'b0;
      over_pulse <= 1'b0;
    end else begin
      over_pulse <= 1'b0;
      case (state)
        IDLE: begin
          game_over <= 1'b0;
          if (any_en) begin
            state <= RUN;
            if (enable_game_classic) begin
              mode       <= MODE_CLASSIC;
              HP_print   <= BAR_W'(HP_INIT);
              time_print <= '0;
            end else begin
              mode       <= MODE_INFINITY;
              HP_print   <= '0;
              time_print <= BAR_W'(TIME_INIT);
            end
          end
        end
        RUN: begin
          if (!any_en) begin
            state      <= IDLE;
            HP_print   <= '0;
            time_print <= '0;
            game_over  <= 1'b0;
          end else if (!paused) begin
            if (mode == MODE_CLASSIC) begin
              if (hit_ok && !pickup) begin
                if (HP_print != '0) HP_print <= HP_print - BAR_W'(1);
                if (HP_print == BAR_W'(1)) begin
                  state      <= OVER;
                  game_over  <= 1'b1;
                  over_pulse <= 1'b1;
                end
              end else if (pickup && !hit_ok) begin
                HP_print <= hp_up;
              end
            end else begin
              time_print <= time_next[BAR_W-1:0];
              if (time_next == 6'd0) begin
                state      <= OVER;
                game_over  <= 1'b1;
                over_pulse <= 1'b1;
              end
            end
          end
        end
        OVER: begin
          if (!any_en) begin
            state      <= IDLE;
            HP_print   <= '0;
            time_print <= '0;
            game_over  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
